bird_sprite_ctrl: RTL

Sequencer and pixel-fetch controller for the bird sprite. It runs the wing-flap animation state machine, advancing only on frame ticks, and selects which of the three 18x12 flap frame ROMs supplies pixels. It converts renderer pixel coordinates into ROM row/col addresses and absorbs the ROMs' one-cycle registered-address latency. It returns a keyed, opaque-flagged 24-bit colour to the screen compositor.

---
 rtl/bird_sprite_pkg.sv | 35 +++
 rtl/bird_anim_fsm.sv | 68 ++++++
 rtl/bird_sprite_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bird_sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bird_sprite_pkg
// Description : Shared constants, animation state encoding and frame indices
//               for the bird sprite controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bird_sprite_pkg;

  localparam int          SPRITE_W   = 18;
  localparam int          SPRITE_H   = 12;
  localparam logic [23:0] KEY_COLOUR = 24'hFF0096;

  typedef enum logic [1:0] {
    GLIDE = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    MID   = 2'd3
  } anim_state_t;

  localparam logic [1:0] FRAME_FLAP1 = 2'd0;
  localparam logic [1:0] FRAME_FLAP2 = 2'd1;
  localparam logic [1:0] FRAME_FLAP3 = 2'd2;

  // Flap ROM index displayed in each animation state
  function automatic logic [1:0] state_frame(input anim_state_t s);
    case (s)
      UP:      return FRAME_FLAP1;
      DOWN:    return FRAME_FLAP3;
      default: return FRAME_FLAP2;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bird_anim_fsm.sv
`default_nettype none
// ============================================================================
// Module      : bird_anim_fsm
// Description : Wing-flap animation sequencer. Holds each flap frame for
//               ANIM_DIV frame ticks and restarts the sequence on every flap.
// Revision    : 1.0 - initial release
// ============================================================================
module bird_anim_fsm
  import bird_sprite_pkg::*;
#(
  parameter int ANIM_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       flap,
  input  logic       anim_en,
  output logic [1:0] anim_frame
);

  localparam logic [3:0] C_DIV = 4'(ANIM_DIV);

  anim_state_t r_state;
  anim_state_t w_state_nxt;
  logic [3:0]  r_hold_cnt;
  logic [3:0]  w_hold_cnt_nxt;
  logic [3:0]  w_hold_cnt_inc;

  assign w_hold_cnt_inc = r_hold_cnt + 4'd1;

  // Next state: flap always restarts at UP and swallows a coincident tick
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    if (anim_en) begin
      if (flap) begin
        w_state_nxt    = UP;
        w_hold_cnt_nxt = 4'd0;
      end else if (frame_tick && (r_state != GLIDE)) begin
        if (w_hold_cnt_inc == C_DIV) begin
          w_hold_cnt_nxt = 4'd0;
          case (r_state)
            UP:      w_state_nxt = DOWN;
            DOWN:    w_state_nxt = MID;
            default: w_state_nxt = GLIDE;
          endcase
        end else begin
          w_hold_cnt_nxt = w_hold_cnt_inc;
        end
      end
    end
  end

  // State, hold counter and registered frame index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= GLIDE;
      r_hold_cnt <= 4'd0;
      anim_frame <= FRAME_FLAP2;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      anim_frame <= state_frame(w_state_nxt);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bird_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bird_sprite_ctrl
// Description : Bird sprite sequencer and pixel fetch. Maps screen pixels to
//               flap ROM addresses, tracks the ROM read latency and returns a
//               colour-keyed pixel three cycles after each request.
// Revision    : 1.0 - initial release
// ============================================================================
module bird_sprite_ctrl
  import bird_sprite_pkg::*;
#(
  parameter int COORD_W  = 9,
  parameter int ANIM_DIV = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               flap,
  input  logic               anim_en,
  input  logic [COORD_W-1:0] bird_x,
  input  logic [COORD_W-1:0] bird_y,
  input  logic               pix_req,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic [3:0]         rom_row,
  output logic [4:0]         rom_col,
  input  logic [23:0]        rom_data0,
  input  logic [23:0]        rom_data1,
  input  logic [23:0]        rom_data2,
  output logic [1:0]         anim_frame,
  output logic               pix_valid,
  output logic [23:0]        pix_colour,
  output logic               pix_opaque
);

  localparam logic signed [COORD_W:0] C_W_LIM = (COORD_W+1)'(SPRITE_W);
  localparam logic signed [COORD_W:0] C_H_LIM = (COORD_W+1)'(SPRITE_H);

  logic signed [COORD_W:0] w_dx;
  logic signed [COORD_W:0] w_dy;
  logic                    w_in_box;
  logic                    r_s1_valid, r_s1_in_box;
  logic [1:0]              r_s1_frame;
  logic                    r_s2_valid, r_s2_in_box;
  logic [1:0]              r_s2_frame;
  logic [23:0]             w_data;
  logic                    w_opaque;

  bird_anim_fsm #(
    .ANIM_DIV (ANIM_DIV)
  ) u_anim_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .flap       (flap),
    .anim_en    (anim_en),
    .anim_frame (anim_frame)
  );

  // Signed offsets keep a bird near the right/bottom edge from wrapping
  assign w_dx     = $signed({1'b0, pix_x}) - $signed({1'b0, bird_x});
  assign w_dy     = $signed({1'b0, pix_y}) - $signed({1'b0, bird_y});
  assign w_in_box = !w_dx[COORD_W] && (w_dx < C_W_LIM) &&
                    !w_dy[COORD_W] && (w_dy < C_H_LIM);

  // Stage 1: ROM address plus the frame select latched with the request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_row     <= 4'd0;
      rom_col     <= 5'd0;
      r_s1_valid  <= 1'b0;
      r_s1_in_box <= 1'b0;
      r_s1_frame  <= FRAME_FLAP2;
    end else begin
      rom_row     <= w_in_box ? w_dy[3:0] : 4'd0;
      rom_col     <= w_in_box ? w_dx[4:0] : 5'd0;
      r_s1_valid  <= pix_req;
      r_s1_in_box <= pix_req && w_in_box;
      r_s1_frame  <= anim_frame;
    end
  end

  // Stage 2: sideband aligned with the ROM's registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_in_box <= 1'b0;
      r_s2_frame  <= FRAME_FLAP2;
    end else begin
      r_s2_valid  <= r_s1_valid;
      r_s2_in_box <= r_s1_in_box;
      r_s2_frame  <= r_s1_frame;
    end
  end

  // ROM select from the latched frame and transparency keying
  always_comb begin
    w_data = rom_data1;
    case (r_s2_frame)
      FRAME_FLAP1: w_data = rom_data0;
      FRAME_FLAP3: w_data = rom_data2;
      default:     w_data = rom_data1;
    endcase
    w_opaque = r_s2_in_box && (w_data != KEY_COLOUR);
  end

  // Stage 3: registered response to the compositor
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid  <= 1'b0;
      pix_opaque <= 1'b0;
      pix_colour <= 24'd0;
    end else begin
      pix_valid  <= r_s2_valid;
      pix_opaque <= w_opaque;
      pix_colour <= w_opaque ? w_data : 24'd0;
    end
  end

endmodule
`default_nettype wire
